// File: rtl/vu_bar_driver_pkg.sv
// Shared constants and types for the VU bar driver.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package vu_bar_driver_pkg;

  // Peak-dot FSM encoding; fixed codes so the state is readable in waves.
  typedef enum logic [1:0] {
    TRACK = 2'd0,
    HOLD  = 2'd1,
    FALL  = 2'd2
  } peak_state_t;

  // Width of the free-running count shared with the mod-16 counter stage.
  localparam int PWM_W = 4;

endpackage

// File: rtl/vu_abs_quant.sv
// Magnitude of a signed sample quantised to a bar height 0..NUM_LEDS.
// Latency: combinational.
// Backpressure: none.
module vu_abs_quant #(
  parameter int SAMPLE_W  = 12,
  parameter int LOG2_LEDS = 3
) (
  input  logic signed [SAMPLE_W-1:0]  sample,
  output logic        [LOG2_LEDS:0]   h
);

  logic [SAMPLE_W-2:0] mag;
  logic                is_min;

  // Absolute value; the most-negative code has no positive twin, so clamp it.
  always_comb begin
    is_min = sample[SAMPLE_W-1] && (sample[SAMPLE_W-2:0] == '0);
    if (is_min)
      mag = '1;
    else if (sample[SAMPLE_W-1])
      mag = ~sample[SAMPLE_W-2:0] + 1'b1;
    else
      mag = sample[SAMPLE_W-2:0];
  end

  // The top LOG2_LEDS magnitude bits pick the segment; any non-zero level lights at least one.
  always_comb begin
    if (mag == '0)
      h = '0;
    else
      h = {1'b0, mag[SAMPLE_W-2 -: LOG2_LEDS]} + (LOG2_LEDS+1)'(1);
  end

endmodule

// File: rtl/vu_bar_driver.sv
// VU bar with fast attack / ticked decay, peak-hold dot and PWM-dimmed LED column.
// Latency: sample -> bar/peak 2 cycles, -> led 3 cycles.
// Backpressure: none; a valid sample is accepted every cycle.
import vu_bar_driver_pkg::*;

module vu_bar_driver #(
  parameter int SAMPLE_W   = 12,
  parameter int NUM_LEDS   = 8,
  parameter int LOG2_LEDS  = 3,
  parameter int HOLD_TICKS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       tick,
  input  logic        [PWM_W-1:0]    pwm_count,
  input  logic        [PWM_W-1:0]    brightness,
  output logic        [LOG2_LEDS:0]  bar,
  output logic        [LOG2_LEDS:0]  peak,
  output logic        [NUM_LEDS-1:0] led
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

  logic [LOG2_LEDS:0]  h_comb;
  logic [LOG2_LEDS:0]  h_q;
  logic                vld_q;
  logic [LOG2_LEDS:0]  bar_nxt;
  logic [LOG2_LEDS:0]  peak_dec;
  logic [7:0]          hold_cnt;
  peak_state_t         state;
  logic [NUM_LEDS-1:0] lit;
  logic                pwm_on;

  vu_abs_quant #(
    .SAMPLE_W  (SAMPLE_W),
    .LOG2_LEDS (LOG2_LEDS)
  ) u_abs_quant (
    .sample (sample),
    .h      (h_comb)
  );

  // Stage 1: register the quantised height with its valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      h_q   <= '0;
    end else begin
      vld_q <= sample_valid;
      h_q   <= h_comb;
    end
  end

  // Next bar: a rising sample wins over a decay tick; decay stops at zero.
  always_comb begin
    bar_nxt = bar;
    if (vld_q && (h_q > bar))
      bar_nxt = h_q;
    else if (tick && (bar != '0))
      bar_nxt = bar - 1'b1;
  end

  assign peak_dec = peak - 1'b1;

  // Stage 2: bar height register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bar <= '0;
    else
      bar <= bar_nxt;
  end

  // Peak-dot FSM: track the bar, hold after a new peak, then fall back onto the bar.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TRACK;
      peak     <= '0;
      hold_cnt <= '0;
    end else if (vld_q && (h_q >= peak) && (h_q != '0)) begin
      peak     <= h_q;
      hold_cnt <= HOLD_INIT;
      state    <= HOLD;
    end else if (peak == '0) begin
      peak  <= bar_nxt;
      state <= TRACK;
    end else begin
      case (state)
        TRACK: peak <= bar_nxt;
        HOLD: begin
          if (bar_nxt > peak)
            peak <= bar_nxt;
          if (tick) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == 8'd1)
              state <= FALL;
          end
        end
        FALL: begin
          if (tick) begin
            if (peak_dec <= bar_nxt) begin
              peak  <= bar_nxt;
              state <= TRACK;
            end else begin
              peak <= peak_dec;
            end
          end else if (bar_nxt >= peak) begin
            peak  <= bar_nxt;
            state <= TRACK;
          end
        end
        default: begin
          peak  <= bar_nxt;
          state <= TRACK;
        end
      endcase
    end
  end

  // Lit pattern: solid column up to the bar plus the single peak dot.
  always_comb begin
    lit = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      lit[i] = (i < int'(bar)) || ((peak != '0) && (i == int'(peak) - 1));
  end

  assign pwm_on = (pwm_count < brightness);

  // LED drive register: gate the pattern with the PWM window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      led <= '0;
    else
      led <= pwm_on ? lit : '0;
  end

endmodule

// File: tb/tb_vu_bar_driver.sv
module tb_vu_bar_driver;

  logic               clk;
  logic               rst;
  logic               sample_valid;
  logic signed [11:0] sample;
  logic               tick;
  logic [3:0]         pwm_count;
  logic [3:0]         brightness;
  logic [3:0]         bar;
  logic [3:0]         peak;
  logic [7:0]         led;

  int total = 0;
  int bad   = 0;

  logic signed [11:0] q_in  [7] = '{12'sd0, 12'sd1, 12'sd255, 12'sd256, 12'sd300, 12'sd2047, -12'sd2048};
  logic [3:0]         q_exp [7] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd8, 4'd8};
  logic [3:0]         d_bar [12] = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0]         d_pk  [12] = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

  vu_bar_driver #(
    .SAMPLE_W   (12),
    .NUM_LEDS   (8),
    .LOG2_LEDS  (3),
    .HOLD_TICKS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .tick         (tick),
    .pwm_count    (pwm_count),
    .brightness   (brightness),
    .bar          (bar),
    .peak         (peak),
    .led          (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0; sample = '0; tick = 1'b0;
    pwm_count = 4'd0; brightness = 4'd15;
    step(); step();
    rst = 1'b0;
  endtask

  // Present one valid sample for a cycle; after return it sits in stage 1.
  task automatic send(input logic signed [11:0] s);
    sample_valid = 1'b1; sample = s;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bar !== 4'd0) begin bad++; $display("FAIL reset_bar got=%0d exp=0", bar); end
    total++; if (peak !== 4'd0) begin bad++; $display("FAIL reset_peak got=%0d exp=0", peak); end
    total++; if (led !== 8'h00) begin bad++; $display("FAIL reset_led got=%h exp=00", led); end
    send(12'sd1280); step();
    total++; if (bar !== 4'd6) begin bad++; $display("FAIL pre_reset_bar got=%0d exp=6", bar); end
    send(12'sd2047);
    rst = 1'b1; #1;
    total++; if (bar !== 4'd0) begin bad++; $display("FAIL async_reset_bar got=%0d exp=0", bar); end
    total++; if (peak !== 4'd0) begin bad++; $display("FAIL async_reset_peak got=%0d exp=0", peak); end
    total++; if (led !== 8'h00) begin bad++; $display("FAIL async_reset_led got=%h exp=00", led); end
    #2; rst = 1'b0;
    step(); step(); step();
    total++; if (bar !== 4'd0) begin bad++; $display("FAIL stale_sample_bar got=%0d exp=0", bar); end
    total++; if (peak !== 4'd0) begin bad++; $display("FAIL stale_sample_peak got=%0d exp=0", peak); end
  endtask

  task automatic test_quant();
    for (int k = 0; k < 7; k++) begin
      do_reset();
      send(q_in[k]);
      total++; if (bar !== 4'd0) begin bad++; $display("FAIL quant_latency[%0d] got=%0d exp=0", k, bar); end
      step();
      total++; if (bar !== q_exp[k]) begin bad++; $display("FAIL quant_bar[%0d] got=%0d exp=%0d", k, bar, q_exp[k]); end
    end
  endtask

  task automatic test_decay();
    do_reset();
    send(12'sd2047); step();
    total++; if (bar !== 4'd8 || peak !== 4'd8) begin bad++; $display("FAIL decay_start got=%0d/%0d exp=8/8", bar, peak); end
    for (int k = 0; k < 12; k++) begin
      do_ticks(1);
      total++; if (bar !== d_bar[k] || peak !== d_pk[k]) begin
        bad++; $display("FAIL decay_tick%0d bar/peak got=%0d/%0d exp=%0d/%0d", k+1, bar, peak, d_bar[k], d_pk[k]);
      end
    end
    do_ticks(1);
    total++; if (bar !== 4'd0 || peak !== 4'd0) begin bad++; $display("FAIL idle_tick got=%0d/%0d exp=0/0", bar, peak); end
  endtask

  task automatic test_track();
    do_reset();
    send(12'sd2047); step();
    do_ticks(5);
    total++; if (bar !== 4'd3 || peak !== 4'd7) begin bad++; $display("FAIL track_setup got=%0d/%0d exp=3/7", bar, peak); end
    send(12'sd1280); tick = 1'b1; step(); tick = 1'b0;
    total++; if (bar !== 4'd6 || peak !== 4'd6) begin bad++; $display("FAIL track_meet got=%0d/%0d exp=6/6", bar, peak); end
    do_ticks(1);
    total++; if (bar !== 4'd5 || peak !== 4'd5) begin bad++; $display("FAIL track_follow1 got=%0d/%0d exp=5/5", bar, peak); end
    do_ticks(1);
    total++; if (bar !== 4'd4 || peak !== 4'd4) begin bad++; $display("FAIL track_follow2 got=%0d/%0d exp=4/4", bar, peak); end
  endtask

  task automatic test_simul();
    do_reset();
    send(12'sd512); step();
    total++; if (bar !== 4'd3 || peak !== 4'd3) begin bad++; $display("FAIL simul_setup got=%0d/%0d exp=3/3", bar, peak); end
    send(12'sd1024); tick = 1'b1; step(); tick = 1'b0;
    total++; if (bar !== 4'd5 || peak !== 4'd5) begin bad++; $display("FAIL simul_rise got=%0d/%0d exp=5/5", bar, peak); end
    do_ticks(2);
    total++; if (bar !== 4'd3 || peak !== 4'd5) begin bad++; $display("FAIL simul_hold got=%0d/%0d exp=3/5", bar, peak); end
    send(12'sd256); tick = 1'b1; step(); tick = 1'b0;
    total++; if (bar !== 4'd2 || peak !== 4'd5) begin bad++; $display("FAIL simul_decay got=%0d/%0d exp=2/5", bar, peak); end
    sample = 12'sd2047; step(); step();
    total++; if (bar !== 4'd2 || peak !== 4'd5) begin bad++; $display("FAIL invalid_ignored got=%0d/%0d exp=2/5", bar, peak); end
  endtask

  task automatic test_retrigger();
    do_reset();
    send(12'sd2047); step();
    do_ticks(6);
    total++; if (bar !== 4'd2 || peak !== 4'd6) begin bad++; $display("FAIL retrig_setup got=%0d/%0d exp=2/6", bar, peak); end
    send(12'sd1280); step();
    total++; if (bar !== 4'd6 || peak !== 4'd6) begin bad++; $display("FAIL retrig_hit got=%0d/%0d exp=6/6", bar, peak); end
    for (int k = 0; k < 4; k++) begin
      do_ticks(1);
      total++; if (bar !== 4'(5-k) || peak !== 4'd6) begin
        bad++; $display("FAIL retrig_hold%0d got=%0d/%0d exp=%0d/6", k+1, bar, peak, 5-k);
      end
    end
    do_ticks(1);
    total++; if (bar !== 4'd1 || peak !== 4'd5) begin bad++; $display("FAIL retrig_fall got=%0d/%0d exp=1/5", bar, peak); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] eb [3] = '{4'd2, 4'd5, 4'd5};
    do_reset();
    sample_valid = 1'b1; sample = 12'sd256;  step();
    sample = 12'sd1024; step();
    total++; if (bar !== eb[0] || peak !== eb[0]) begin bad++; $display("FAIL b2b_0 got=%0d/%0d exp=%0d", bar, peak, eb[0]); end
    sample = 12'sd512; step();
    total++; if (bar !== eb[1] || peak !== eb[1]) begin bad++; $display("FAIL b2b_1 got=%0d/%0d exp=%0d", bar, peak, eb[1]); end
    sample_valid = 1'b0; step();
    total++; if (bar !== eb[2] || peak !== eb[2]) begin bad++; $display("FAIL b2b_2 got=%0d/%0d exp=%0d", bar, peak, eb[2]); end
  endtask

  task automatic test_pwm();
    logic [3:0] br [3] = '{4'd4, 4'd0, 4'd15};
    logic [7:0] exp_led;
    do_reset();
    send(12'sd1280); step();
    do_ticks(3);
    total++; if (bar !== 4'd3 || peak !== 4'd6) begin bad++; $display("FAIL pwm_setup got=%0d/%0d exp=3/6", bar, peak); end
    for (int b = 0; b < 3; b++) begin
      brightness = br[b];
      for (int c = 0; c < 16; c++) begin
        pwm_count = 4'(c);
        step();
        exp_led = (c < int'(br[b])) ? 8'b0010_0111 : 8'h00;
        total++; if (led !== exp_led) begin
          bad++; $display("FAIL pwm_b%0d_c%0d led got=%h exp=%h", br[b], c, led, exp_led);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_quant();
    test_decay();
    test_track();
    test_simul();
    test_retrigger();
    test_back_to_back();
    test_pwm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
